// File: rtl/except_req_gen.sv
// Commit-side exception request generator: stalls commit on a faulting/ERET/interrupted ROB head,
// waits for committed stores to drain, pulses a registered exception request, then holds for the flush.
module except_req_gen #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned ADDR_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  head_valid,
  input  logic                  head_ex,
  input  logic [4:0]            head_excode,
  input  logic                  head_eret,
  input  logic                  head_delayslot,
  input  logic [ADDR_WIDTH-1:0] head_pc,
  input  logic [ADDR_WIDTH-1:0] head_badva,
  input  logic                  irq_pending,
  input  logic                  sb_empty,
  output logic                  commit_stall,
  output logic                  busy,
  output logic                  except_valid,
  output logic                  except_eret,
  output logic [4:0]            except_code,
  output logic [ADDR_WIDTH-1:0] except_epc,
  output logic [ADDR_WIDTH-1:0] except_badva,
  output logic                  except_bd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    REQ   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0]      CNT_LOAD   = CNT_W'(FLUSH_CYCLES - 32'd1);
  localparam logic [ADDR_WIDTH-1:0] INSN_BYTES = ADDR_WIDTH'(32'd4);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = {ADDR_WIDTH{1'b0}};

  state_t                  state_r;
  logic [CNT_W-1:0]        cnt_r;
  logic                    trigger_s;

  logic                    nxt_eret_s;
  logic [4:0]              nxt_code_s;
  logic [ADDR_WIDTH-1:0]   nxt_epc_s;
  logic [ADDR_WIDTH-1:0]   nxt_badva_s;
  logic                    nxt_bd_s;
  logic [ADDR_WIDTH-1:0]   fault_epc_s;

  logic                    lat_eret_r;
  logic [4:0]              lat_code_r;
  logic [ADDR_WIDTH-1:0]   lat_epc_r;
  logic [ADDR_WIDTH-1:0]   lat_badva_r;
  logic                    lat_bd_r;

  logic                    except_valid_r;
  logic                    except_eret_r;
  logic [4:0]              except_code_r;
  logic [ADDR_WIDTH-1:0]   except_epc_r;
  logic [ADDR_WIDTH-1:0]   except_badva_r;
  logic                    except_bd_r;

  // The triggering instruction is blocked in the same cycle it reaches the head.
  assign trigger_s    = (state_r == IDLE) & head_valid & (irq_pending | head_ex | head_eret);
  assign commit_stall = trigger_s | (state_r != IDLE);
  assign busy         = (state_r != IDLE);

  // Delay-slot faults restart at the branch; wraps modulo 2^ADDR_WIDTH.
  assign fault_epc_s  = head_delayslot ? (head_pc - INSN_BYTES) : head_pc;

  // Select the request fields by priority: interrupt, then exception, then ERET.
  always_comb begin
    nxt_eret_s  = 1'b0;
    nxt_code_s  = 5'd0;
    nxt_epc_s   = head_pc;
    nxt_badva_s = ADDR_ZERO;
    nxt_bd_s    = 1'b0;
    if (irq_pending) begin
      nxt_epc_s = fault_epc_s;
      nxt_bd_s  = head_delayslot;
    end else if (head_ex) begin
      nxt_code_s  = head_excode;
      nxt_epc_s   = fault_epc_s;
      nxt_badva_s = head_badva;
      nxt_bd_s    = head_delayslot;
    end else if (head_eret) begin
      nxt_eret_s = 1'b1;
    end else begin
      nxt_eret_s = 1'b0;
    end
  end

  // Sequencer plus registered request outputs, which are non-zero only while in REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      cnt_r          <= {CNT_W{1'b0}};
      lat_eret_r     <= 1'b0;
      lat_code_r     <= 5'd0;
      lat_epc_r      <= ADDR_ZERO;
      lat_badva_r    <= ADDR_ZERO;
      lat_bd_r       <= 1'b0;
      except_valid_r <= 1'b0;
      except_eret_r  <= 1'b0;
      except_code_r  <= 5'd0;
      except_epc_r   <= ADDR_ZERO;
      except_badva_r <= ADDR_ZERO;
      except_bd_r    <= 1'b0;
    end else begin
      except_valid_r <= 1'b0;
      except_eret_r  <= 1'b0;
      except_code_r  <= 5'd0;
      except_epc_r   <= ADDR_ZERO;
      except_badva_r <= ADDR_ZERO;
      except_bd_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (trigger_s) begin
            lat_eret_r  <= nxt_eret_s;
            lat_code_r  <= nxt_code_s;
            lat_epc_r   <= nxt_epc_s;
            lat_badva_r <= nxt_badva_s;
            lat_bd_r    <= nxt_bd_s;
            state_r     <= DRAIN;
          end
        end
        DRAIN: begin
          if (sb_empty) begin
            except_valid_r <= 1'b1;
            except_eret_r  <= lat_eret_r;
            except_code_r  <= lat_code_r;
            except_epc_r   <= lat_epc_r;
            except_badva_r <= lat_badva_r;
            except_bd_r    <= lat_bd_r;
            state_r        <= REQ;
          end
        end
        REQ: begin
          cnt_r   <= CNT_LOAD;
          state_r <= HOLD;
        end
        HOLD: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1'b1);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign except_valid = except_valid_r;
  assign except_eret  = except_eret_r;
  assign except_code  = except_code_r;
  assign except_epc   = except_epc_r;
  assign except_badva = except_badva_r;
  assign except_bd    = except_bd_r;

endmodule
